// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
//   NREQ   : number of requesters (fixed at 4, matches the mux width)
//   SEL_W  : width of the mux select / grant index
//   state_t: arbiter state (IDLE, BUSY)
//   pick_t : result of a round-robin search (found flag + winning index)
package mux4_arb_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set request bit at or after ptr, ascending, wrapping modulo NREQ.
  // Offsets are scanned from highest to lowest, so the smallest offset is
  // written last and therefore wins.
  function automatic pick_t rr_pick(input logic [NREQ-1:0]  req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] k;
    p = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = ptr + SEL_W'(i);
      if (req[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter.sv
// Round-robin scheduler for a shared 4-input mux. Holds a one-hot grant for
// at most MAX_HOLD consecutive cycles, then rotates to the next requester.
// Ports:
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   REQ   : level request per requester
//   GNT   : registered one-hot grant, or all zero
//   SEL   : mux select, index of the current or last grant
//   VALID : high while any GNT bit is set
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [NREQ-1:0]  REQ,
  output logic [NREQ-1:0]  GNT,
  output logic [SEL_W-1:0] SEL,
  output logic             VALID
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  state_t            r_state;
  logic [SEL_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [NREQ-1:0]   r_gnt;
  logic [SEL_W-1:0]  r_sel;
  logic              r_valid;

  logic              w_release;
  logic [SEL_W-1:0]  w_ptr_eff;
  pick_t             w_pick;

  // While BUSY, r_sel is the index of the current grant.
  always_comb begin
    w_release = (r_state == BUSY) &&
                (!REQ[r_sel] || (r_cnt == CNT_W'(MAX_HOLD)));
    // On release the pointer moves past the holder in the same edge, so the
    // holder becomes lowest priority for this pick.
    w_ptr_eff = w_release ? (r_sel + SEL_W'(1)) : r_ptr;
    w_pick    = rr_pick(REQ, w_ptr_eff);
  end

  // State, pointer, tenure counter and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick.found) begin
            r_gnt   <= NREQ'(1) << w_pick.idx;
            r_sel   <= w_pick.idx;
            r_valid <= 1'b1;
            r_cnt   <= CNT_W'(1);
            r_state <= BUSY;
          end else begin
            // SEL keeps its last value to avoid toggling the mux select.
            r_gnt   <= '0;
            r_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (!w_release) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_ptr <= w_ptr_eff;
            if (w_pick.found) begin
              // Handoff without a bubble cycle.
              r_gnt <= NREQ'(1) << w_pick.idx;
              r_sel <= w_pick.idx;
              r_cnt <= CNT_W'(1);
            end else begin
              r_gnt   <= '0;
              r_valid <= 1'b0;
              r_cnt   <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign GNT   = r_gnt;
  assign SEL   = r_sel;
  assign VALID = r_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with MAX_HOLD=4, plus a randomized
// datapath/starvation scenario using a behavioural 4:1 mux.
module tb_mux4_rr_arbiter;

  localparam int unsigned MH = 4;

  logic       CLK;
  logic       RST_N;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [1:0] SEL;
  logic       VALID;

  int checks   = 0;
  int failures = 0;

  // Mux data inputs A..D = 1,0,1,0 and the mux output driven by SEL.
  logic [3:0] mux_data;
  logic       mux_out;
  assign mux_out = mux_data[SEL];

  mux4_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .REQ  (REQ),
    .GNT  (GNT),
    .SEL  (SEL),
    .VALID(VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    REQ   = 4'b0000;
    RST_N = 1'b0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    REQ   = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (GNT !== 4'b0000 || SEL !== 2'b00 || VALID !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d: gnt=%b sel=%b valid=%b, required 0000/00/0",
                 c, GNT, SEL, VALID);
      end
    end
    // First grant is sampled at the first edge after deassertion.
    REQ   = 4'b0100;
    RST_N = 1'b1;
    step();
    checks++;
    if (GNT !== 4'b0100 || SEL !== 2'b10 || VALID !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant: gnt=%b sel=%b valid=%b, required 0100/10/1",
               GNT, SEL, VALID);
    end
    // Asynchronous reset between edges.
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (GNT !== 4'b0000 || VALID !== 1'b0 || SEL !== 2'b00) begin
      failures++;
      $display("FAIL reset_async: gnt=%b sel=%b valid=%b, required 0000/00/0",
               GNT, SEL, VALID);
    end
    checks++;
    if (dut.r_ptr !== 2'd0) begin
      failures++;
      $display("FAIL reset_ptr: ptr=%0d, required 0", dut.r_ptr);
    end
    step();
    RST_N = 1'b1;
    REQ   = 4'b0000;
  endtask

  task automatic test_single();
    logic [2:0] exp_cnt;
    do_reset();
    REQ = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step();
      exp_cnt = 3'((c % 4) + 1);
      checks++;
      if (GNT !== 4'b0001 || SEL !== 2'b00 || VALID !== 1'b1) begin
        failures++;
        $display("FAIL single_grant cyc=%0d: gnt=%b sel=%b valid=%b, required 0001/00/1",
                 c, GNT, SEL, VALID);
      end
      checks++;
      if (dut.r_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL single_cnt cyc=%0d: cnt=%0d, required %0d", c, dut.r_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_all_requesting();
    logic [1:0] exp_idx;
    logic [3:0] exp_gnt;
    do_reset();
    REQ = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      exp_idx = 2'((c / 4) % 4);
      exp_gnt = 4'b0001 << exp_idx;
      checks++;
      if (GNT !== exp_gnt || SEL !== exp_idx || VALID !== 1'b1) begin
        failures++;
        $display("FAIL all_rotate cyc=%0d: gnt=%b sel=%b valid=%b, required %b/%b/1",
                 c, GNT, SEL, VALID, exp_gnt, exp_idx);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    REQ = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (GNT !== 4'b0100 || SEL !== 2'b10 || VALID !== 1'b1) begin
        failures++;
        $display("FAIL early_hold cyc=%0d: gnt=%b sel=%b valid=%b, required 0100/10/1",
                 c, GNT, SEL, VALID);
      end
    end
    REQ = 4'b0000;
    step();
    checks++;
    if (GNT !== 4'b0000 || VALID !== 1'b0 || SEL !== 2'b10) begin
      failures++;
      $display("FAIL early_idle: gnt=%b sel=%b valid=%b, required 0000/10/0",
               GNT, SEL, VALID);
    end
    checks++;
    if (dut.r_ptr !== 2'd3) begin
      failures++;
      $display("FAIL early_ptr: ptr=%0d, required 3", dut.r_ptr);
    end
    step();
    checks++;
    if (GNT !== 4'b0000 || VALID !== 1'b0 || SEL !== 2'b10) begin
      failures++;
      $display("FAIL early_idle_hold: gnt=%b sel=%b valid=%b, required 0000/10/0",
               GNT, SEL, VALID);
    end
    REQ = 4'b1001;
    step();
    checks++;
    if (GNT !== 4'b1000 || SEL !== 2'b11 || VALID !== 1'b1) begin
      failures++;
      $display("FAIL early_ptr_pick: gnt=%b sel=%b valid=%b, required 1000/11/1",
               GNT, SEL, VALID);
    end
    REQ = 4'b0001;
    step();
    checks++;
    if (GNT !== 4'b0001 || SEL !== 2'b00 || VALID !== 1'b1) begin
      failures++;
      $display("FAIL early_switch: gnt=%b sel=%b valid=%b, required 0001/00/1",
               GNT, SEL, VALID);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    REQ = 4'b0010;
    step();
    step();
    checks++;
    if (GNT !== 4'b0010 || SEL !== 2'b01 || VALID !== 1'b1) begin
      failures++;
      $display("FAIL b2b_setup: gnt=%b sel=%b valid=%b, required 0010/01/1",
               GNT, SEL, VALID);
    end
    REQ = 4'b0101;
    step();
    checks++;
    if (GNT !== 4'b0100 || SEL !== 2'b10 || VALID !== 1'b1) begin
      failures++;
      $display("FAIL b2b_handoff: gnt=%b sel=%b valid=%b, required 0100/10/1",
               GNT, SEL, VALID);
    end
  endtask

  task automatic test_random_datapath();
    int         wait_cnt [4];
    logic [3:0] req_v;
    int         gidx;
    int         ones;
    do_reset();
    mux_data = 4'b0101;
    req_v    = 4'b0000;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 200; c++) begin
      // Hold requests until served; drop sometimes once granted.
      for (int i = 0; i < 4; i++) begin
        if (!req_v[i]) req_v[i] = ($urandom_range(1, 0) == 1);
        else if (GNT[i]) req_v[i] = ($urandom_range(2, 0) != 0);
      end
      REQ = req_v;
      step();
      ones = $countones(GNT);
      checks++;
      if (ones > 1 || VALID !== (GNT != 4'b0000)) begin
        failures++;
        $display("FAIL rand_onehot cyc=%0d: gnt=%b valid=%b, required one-hot/zero with valid=|gnt",
                 c, GNT, VALID);
      end
      if (VALID === 1'b1) begin
        gidx = 0;
        for (int i = 0; i < 4; i++) if (GNT[i]) gidx = i;
        checks++;
        if (mux_out !== mux_data[gidx]) begin
          failures++;
          $display("FAIL rand_mux cyc=%0d: out=%b sel=%b gnt=%b, required %b",
                   c, mux_out, SEL, GNT, mux_data[gidx]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_v[i] && !GNT[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > int'(3 * MH + 1)) begin
          checks++;
          failures++;
          $display("FAIL rand_starve cyc=%0d req=%0d: waited %0d, required <= %0d",
                   c, i, wait_cnt[i], 3 * MH + 1);
          wait_cnt[i] = 0;
        end
      end
    end
    REQ = 4'b0000;
  endtask

  initial begin
    RST_N    = 1'b0;
    REQ      = 4'b0000;
    mux_data = 4'b0101;
    test_reset();
    test_single();
    test_all_requesting();
    test_early_release();
    test_back_to_back();
    test_random_datapath();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin scheduler that shares the 4-input mux (Dmux4way) among four requesters.
- Registers one-hot grant lines.
- Drives the mux SEL[1:0] from the granted index.
- Caps each tenure at MAX_HOLD cycles so no requester starves the others.
- Sits directly in front of the mux SEL input; VALID qualifies the mux OUT for the consumer.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one grant may last; legal range 1..15 (1 = rotate every cycle)
NREQ, 4, number of requesters; fixed at 4 to match mux width, not overridable

Ports:
CLK  input  1  clock, rising-edge
RST_N  input  1  asynchronous active-low reset
REQ  input  4  level request per requester; held high while access wanted
GNT  output  4  one-hot registered grant, or all zero
SEL  output  2  mux select; index of current or last grant
VALID  output  1  high while any GNT bit is set; mux OUT is meaningful

Behaviour:
- Reset (RST_N low, async, takes effect with no clock edge):
  - GNT=0000, SEL=00, VALID=0.
  - state=IDLE, round-robin pointer PTR=0, hold counter CNT=0.
- All outputs are registered. Latency from REQ rising to GNT is 1 cycle.
- Pick rule: search REQ starting at index PTR, ascending, wrapping modulo 4; first set bit wins.
- IDLE, on each edge:
  - REQ==0000: stay IDLE; outputs unchanged except VALID=0. SEL holds its last value (no toggling).
  - Otherwise: grant winner w. GNT=onehot(w), SEL=w, VALID=1, CNT=1, go BUSY.
- BUSY with grant g, on each edge, release occurs if REQ[g]==0 or CNT==MAX_HOLD.
  - No release: hold grant, CNT=CNT+1.
  - Release: PTR=(g+1) mod 4, then pick from REQ sampled at the same edge.
    - A winner exists: switch grant in the same edge with no bubble cycle. CNT=1, stay BUSY.
    - g itself may win only if it still requests and no other requester does, because g has lowest priority after PTR update.
    - No winner: GNT=0000, VALID=0, go IDLE.
- Release and new-request evaluation happen at the same edge. A requester that deasserts and reasserts between edges is seen only by its level at the edge.
- GNT is never multi-hot; VALID==|GNT at all times.
- CNT width is $clog2(MAX_HOLD+1). CNT never exceeds MAX_HOLD and never wraps.
- Reset asserted mid-grant: GNT and VALID drop asynchronously; PTR returns to 0.
- Reset deassertion: the first grant is sampled on the first rising edge after RST_N goes high.

Decomposition:
- Package mux4_arb_pkg:
  - NREQ=4, SEL_W=2.
  - state enum {IDLE, BUSY}.
  - pure function rr_pick(req[3:0], ptr[1:0]) returning found flag and index.
- No sub-module: a single always_ff for state/PTR/CNT/outputs plus a combinational pick is natural.
- Top-level integration instantiates mux4_rr_arbiter beside Dmux4way, SEL to SEL.

Test Plan:
1. Reset: RST_N=0 with REQ=1111 and CLK running -> GNT=0000, SEL=00, VALID=0 throughout. Pull RST_N=0 while GNT=0100 between edges -> GNT=0000 before the next edge.
2. Single requester, MAX_HOLD=4: REQ=0001 held 10 cycles -> GNT=0001 from cycle 1 continuously with no bubble. CNT sequence 1,2,3,4,1,2,3,4,1,2; SEL=00; VALID=1.
3. All requesting, MAX_HOLD=4: REQ=1111 held 20 cycles -> GNT 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 x4. SEL 00,01,10,11,00. VALID never drops.
4. Early release and pointer: REQ=0100 for 2 cycles, then 0000 -> GNT=0100 for 2 cycles, then 0000 and IDLE (PTR=3). Next REQ=1001 -> GNT=1000 first. Drop REQ[3] -> GNT=0001 next edge.
5. Back-to-back handoff: grant on 0010, at the edge where REQ[1] drops REQ=0101 -> GNT=0100 at that same edge; VALID stays 1.
6. Datapath check with Dmux4way: A..D=1,0,1,0 and random REQ for 200 cycles -> whenever VALID=1, mux OUT equals the input selected by SEL. GNT is always one-hot or zero. No requester waits more than 3*MAX_HOLD+1 cycles.
